// File: rtl/video_timing_rx.sv
// Video timing receiver: samples hs/vs/hb/vb on the pixel enable, rebuilds beam position and
// measures line/frame geometry, asserting locked once consecutive frames measure identically.
module video_timing_rx #(
    parameter int unsigned W             = 9,
    parameter bit          HS_ACTIVE_LOW = 1'b1,
    parameter bit          VS_ACTIVE_LOW = 1'b1,
    parameter int unsigned LOCK_FRAMES   = 2
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         ce_pix,
    input  logic         hs,
    input  logic         vs,
    input  logic         hb,
    input  logic         vb,
    output logic [W-1:0] hpos,
    output logic [W-1:0] vpos,
    output logic [W-1:0] h_total,
    output logic [W-1:0] v_total,
    output logic [W-1:0] h_active,
    output logic [W-1:0] v_active,
    output logic [W-1:0] hs_width,
    output logic         frame_start,
    output logic         locked
);

    localparam logic [W-1:0] CntMax     = '1;
    localparam logic [3:0]   LockFrames = 4'(LOCK_FRAMES);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == CntMax) ? v : v + 1'b1;
    endfunction

    // Sync inputs normalised to active-high
    logic w_hs_n;
    logic w_vs_n;
    assign w_hs_n = HS_ACTIVE_LOW ? ~hs : hs;
    assign w_vs_n = VS_ACTIVE_LOW ? ~vs : vs;

    // Horizontal state
    logic         r_hs_prev,  w_hs_prev_d;
    logic [W-1:0] r_hpos,     w_hpos_d;
    logic [W-1:0] r_hact,     w_hact_d;
    logic [W-1:0] r_hsw,      w_hsw_d;
    logic         r_h_primed, w_h_primed_d;
    logic [W-1:0] r_h_total,  w_h_total_d;
    logic [W-1:0] r_h_active, w_h_active_d;
    logic [W-1:0] r_hs_width, w_hs_width_d;

    // Vertical state
    logic         r_vs_prev,     w_vs_prev_d;
    logic [W-1:0] r_ln,          w_ln_d;
    logic [W-1:0] r_vact,        w_vact_d;
    logic [W-1:0] r_vpos,        w_vpos_d;
    logic         r_v_primed,    w_v_primed_d;
    logic [W-1:0] r_v_total,     w_v_total_d;
    logic [W-1:0] r_v_active,    w_v_active_d;
    logic         r_frame_start, w_frame_start_d;

    // Lock state: snapshot of the previous frame's measurement
    logic [W-1:0] r_snap_ht,  w_snap_ht_d;
    logic [W-1:0] r_snap_vt,  w_snap_vt_d;
    logic [W-1:0] r_snap_ha,  w_snap_ha_d;
    logic [W-1:0] r_snap_va,  w_snap_va_d;
    logic         r_snap_vld, w_snap_vld_d;
    logic [3:0]   r_stable,   w_stable_d;
    logic         r_locked,   w_locked_d;

    logic w_hs_lead;
    logic w_hs_trail;
    logic w_vs_lead;
    logic w_los;
    logic w_vs_meas;
    logic w_match;

    assign w_hs_lead  = ce_pix & w_hs_n & ~r_hs_prev;
    assign w_hs_trail = ce_pix & ~w_hs_n & r_hs_prev;
    assign w_vs_lead  = ce_pix & w_vs_n & ~r_vs_prev;
    // A saturated counter means sync has gone missing; the current measurement is meaningless
    assign w_los      = ce_pix & ((r_hpos == CntMax) | (r_ln == CntMax));
    assign w_vs_meas  = w_vs_lead & r_v_primed & ~w_los;
    assign w_match    = r_snap_vld &
                        ({w_h_total_d, r_ln, w_h_active_d, r_vact} ==
                         {r_snap_ht, r_snap_vt, r_snap_ha, r_snap_va});

    always_comb begin
        w_hs_prev_d  = r_hs_prev;
        w_hpos_d     = r_hpos;
        w_hact_d     = r_hact;
        w_hsw_d      = r_hsw;
        w_h_primed_d = r_h_primed;
        w_h_total_d  = r_h_total;
        w_h_active_d = r_h_active;
        w_hs_width_d = r_hs_width;
        if (ce_pix) begin
            w_hs_prev_d = w_hs_n;
            if (w_los) begin
                w_h_primed_d = 1'b0;
            end
            if (w_hs_lead) begin
                w_hpos_d = '0;
                if (r_h_primed && !w_los) begin
                    w_h_total_d  = sat_inc(r_hpos);
                    w_h_active_d = r_hact;
                end
                w_hact_d     = '0;
                w_hsw_d      = '0;
                w_h_primed_d = 1'b1;
            end else begin
                w_hpos_d = sat_inc(r_hpos);
                if (!hb) begin
                    w_hact_d = sat_inc(r_hact);
                end
                if (w_hs_n) begin
                    w_hsw_d = sat_inc(r_hsw);
                end
            end
            if (w_hs_trail) begin
                w_hs_width_d = sat_inc(r_hsw);
            end
        end
    end

    always_comb begin
        w_vs_prev_d     = r_vs_prev;
        w_ln_d          = r_ln;
        w_vact_d        = r_vact;
        w_vpos_d        = r_vpos;
        w_v_primed_d    = r_v_primed;
        w_v_total_d     = r_v_total;
        w_v_active_d    = r_v_active;
        w_frame_start_d = 1'b0;
        if (ce_pix) begin
            w_vs_prev_d = w_vs_n;
            if (w_los) begin
                w_v_primed_d = 1'b0;
            end
            if (w_vs_lead) begin
                if (w_vs_meas) begin
                    w_v_total_d  = r_ln;
                    w_v_active_d = r_vact;
                end
                // A line whose hs edge coincides with vs belongs to the new frame
                w_ln_d          = {{(W-1){1'b0}}, w_hs_lead};
                w_vact_d        = {{(W-1){1'b0}}, w_hs_lead & ~vb};
                w_vpos_d        = '0;
                w_v_primed_d    = 1'b1;
                w_frame_start_d = 1'b1;
            end else if (w_hs_lead) begin
                w_ln_d   = sat_inc(r_ln);
                w_vpos_d = sat_inc(r_vpos);
                if (!vb) begin
                    w_vact_d = sat_inc(r_vact);
                end
            end
        end
    end

    always_comb begin
        w_snap_ht_d  = r_snap_ht;
        w_snap_vt_d  = r_snap_vt;
        w_snap_ha_d  = r_snap_ha;
        w_snap_va_d  = r_snap_va;
        w_snap_vld_d = r_snap_vld;
        w_stable_d   = r_stable;
        w_locked_d   = r_locked;
        if (w_los) begin
            w_snap_vld_d = 1'b0;
            w_stable_d   = '0;
            w_locked_d   = 1'b0;
        end
        if (w_vs_meas) begin
            // First measurement after priming starts a run of one stable frame
            if (!r_snap_vld) begin
                w_stable_d = 4'd1;
            end else if (w_match) begin
                w_stable_d = (r_stable < LockFrames) ? r_stable + 4'd1 : r_stable;
            end else begin
                w_stable_d = '0;
            end
            w_locked_d   = (w_stable_d != '0) && (w_stable_d >= LockFrames);
            w_snap_ht_d  = w_h_total_d;
            w_snap_vt_d  = r_ln;
            w_snap_ha_d  = w_h_active_d;
            w_snap_va_d  = r_vact;
            w_snap_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_hs_prev     <= 1'b0;
            r_hpos        <= '0;
            r_hact        <= '0;
            r_hsw         <= '0;
            r_h_primed    <= 1'b0;
            r_h_total     <= '0;
            r_h_active    <= '0;
            r_hs_width    <= '0;
            r_vs_prev     <= 1'b0;
            r_ln          <= '0;
            r_vact        <= '0;
            r_vpos        <= '0;
            r_v_primed    <= 1'b0;
            r_v_total     <= '0;
            r_v_active    <= '0;
            r_frame_start <= 1'b0;
            r_snap_ht     <= '0;
            r_snap_vt     <= '0;
            r_snap_ha     <= '0;
            r_snap_va     <= '0;
            r_snap_vld    <= 1'b0;
            r_stable      <= '0;
            r_locked      <= 1'b0;
        end else begin
            r_hs_prev     <= w_hs_prev_d;
            r_hpos        <= w_hpos_d;
            r_hact        <= w_hact_d;
            r_hsw         <= w_hsw_d;
            r_h_primed    <= w_h_primed_d;
            r_h_total     <= w_h_total_d;
            r_h_active    <= w_h_active_d;
            r_hs_width    <= w_hs_width_d;
            r_vs_prev     <= w_vs_prev_d;
            r_ln          <= w_ln_d;
            r_vact        <= w_vact_d;
            r_vpos        <= w_vpos_d;
            r_v_primed    <= w_v_primed_d;
            r_v_total     <= w_v_total_d;
            r_v_active    <= w_v_active_d;
            r_frame_start <= w_frame_start_d;
            r_snap_ht     <= w_snap_ht_d;
            r_snap_vt     <= w_snap_vt_d;
            r_snap_ha     <= w_snap_ha_d;
            r_snap_va     <= w_snap_va_d;
            r_snap_vld    <= w_snap_vld_d;
            r_stable      <= w_stable_d;
            r_locked      <= w_locked_d;
        end
    end

    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign h_total     = r_h_total;
    assign v_total     = r_v_total;
    assign h_active    = r_h_active;
    assign v_active    = r_v_active;
    assign hs_width    = r_hs_width;
    assign frame_start = r_frame_start;
    assign locked      = r_locked;

endmodule

// File: tb/tb_video_timing_rx.sv
// Scoreboard bench for video_timing_rx: each generated frame pushes its expected measurement,
// and a monitor pops and compares on every frame_start pulse.
module tb_video_timing_rx;

    localparam int W = 9;

    logic         clk_sys = 1'b0;
    logic         reset;
    logic         ce_pix;
    logic         hs;
    logic         vs;
    logic         hb;
    logic         vb;
    logic [W-1:0] hpos;
    logic [W-1:0] vpos;
    logic [W-1:0] h_total;
    logic [W-1:0] v_total;
    logic [W-1:0] h_active;
    logic [W-1:0] v_active;
    logic [W-1:0] hs_width;
    logic         frame_start;
    logic         locked;

    always #5 clk_sys = ~clk_sys;

    video_timing_rx #(
        .W             (W),
        .HS_ACTIVE_LOW (1'b1),
        .VS_ACTIVE_LOW (1'b1),
        .LOCK_FRAMES   (2)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ce_pix      (ce_pix),
        .hs          (hs),
        .vs          (vs),
        .hb          (hb),
        .vb          (vb),
        .hpos        (hpos),
        .vpos        (vpos),
        .h_total     (h_total),
        .v_total     (v_total),
        .h_active    (h_active),
        .v_active    (v_active),
        .hs_width    (hs_width),
        .frame_start (frame_start),
        .locked      (locked)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Stream geometry
    int ce_div;
    int htot;
    int hs0;
    int hs1;
    int ha0;
    int ha1;
    int vb_lines;
    int vs_line;
    int vs_px;

    typedef struct {
        int ht;
        int ha;
        int hw;
        int vt;
        int va;
        int lk;
        int hp;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   n_push = 0;
    int   n_pop  = 0;
    logic fs_prev = 1'b0;

    task automatic expect_frame(input int ht, input int ha, input int hw, input int vt,
                                input int va, input int lk, input int hp);
        exp_t e;
        e.ht = ht;
        e.ha = ha;
        e.hw = hw;
        e.vt = vt;
        e.va = va;
        e.lk = lk;
        e.hp = hp;
        exp_q.push_back(e);
        n_push++;
    endtask

    always @(negedge clk_sys) begin
        if (frame_start) begin
            chk($sformatf("f%0d_frame_start_width", n_pop), int'(fs_prev), 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame_start_unexpected: got a pulse, expected none");
            end else begin
                m_e = exp_q.pop_front();
                chk($sformatf("f%0d_h_total", n_pop), int'(h_total), m_e.ht);
                chk($sformatf("f%0d_h_active", n_pop), int'(h_active), m_e.ha);
                chk($sformatf("f%0d_hs_width", n_pop), int'(hs_width), m_e.hw);
                chk($sformatf("f%0d_v_total", n_pop), int'(v_total), m_e.vt);
                chk($sformatf("f%0d_v_active", n_pop), int'(v_active), m_e.va);
                chk($sformatf("f%0d_locked", n_pop), int'(locked), m_e.lk);
                chk($sformatf("f%0d_hpos", n_pop), int'(hpos), m_e.hp);
                chk($sformatf("f%0d_vpos", n_pop), int'(vpos), 0);
                n_pop++;
            end
        end
        fs_prev = frame_start;
    end

    // One pixel: ce_div-1 idle clocks then one clock with ce_pix high; syncs driven active-low
    task automatic pix(input logic hs_a, input logic vs_a, input logic hb_v, input logic vb_v);
        for (int i = 1; i < ce_div; i++) begin
            @(negedge clk_sys);
            ce_pix = 1'b0;
        end
        @(negedge clk_sys);
        hs     = ~hs_a;
        vs     = ~vs_a;
        hb     = hb_v;
        vb     = vb_v;
        ce_pix = 1'b1;
    endtask

    task automatic send_lines(input int first, input int last);
        int   vstart;
        int   pos;
        logic hs_a;
        logic vs_a;
        vstart = vs_line * htot + vs_px;
        for (int ln = first; ln <= last; ln++) begin
            for (int px = 0; px < htot; px++) begin
                pos  = ln * htot + px;
                hs_a = (px >= hs0) && (px <= hs1);
                vs_a = (pos >= vstart) && (pos < vstart + 3 * htot);
                pix(hs_a, vs_a, !((px >= ha0) && (px <= ha1)), !(ln < vb_lines));
            end
        end
    endtask

    task automatic settle();
        @(negedge clk_sys);
        ce_pix = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_hpos"}, int'(hpos), 0);
        chk({tag, "_vpos"}, int'(vpos), 0);
        chk({tag, "_h_total"}, int'(h_total), 0);
        chk({tag, "_v_total"}, int'(v_total), 0);
        chk({tag, "_h_active"}, int'(h_active), 0);
        chk({tag, "_v_active"}, int'(v_active), 0);
        chk({tag, "_hs_width"}, int'(hs_width), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
        chk({tag, "_locked"}, int'(locked), 0);
    endtask

    task automatic idle_reset();
        @(negedge clk_sys);
        ce_pix = 1'b0;
        reset  = 1'b1;
        hs     = 1'b1;
        vs     = 1'b1;
        hb     = 1'b1;
        vb     = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        ce_pix = 1'b0;
        hs     = 1'b1;
        vs     = 1'b1;
        hb     = 1'b1;
        vb     = 1'b1;
        repeat (3) @(negedge clk_sys);
        check_zero("reset");
        reset = 1'b0;

        // Full-size line geometry, ce every 7 clocks, one short frame to flush via frame_start
        ce_div   = 7;
        htot     = 384;
        hs0      = 309;
        hs1      = 340;
        ha0      = 5;
        ha1      = 244;
        vb_lines = 0;
        vs_line  = 2;
        vs_px    = 0;
        expect_frame(384, 240, 32, 0, 0, 0, 75);
        send_lines(0, 3);
        idle_reset();

        // 263-line frames with short lines; lock at the third vs edge
        ce_div   = 2;
        htot     = 8;
        hs0      = 5;
        hs1      = 6;
        ha0      = 1;
        ha1      = 3;
        vb_lines = 224;
        vs_line  = 234;
        vs_px    = 0;
        expect_frame(8, 3, 2, 0, 0, 0, 3);
        send_lines(0, 262);
        expect_frame(8, 3, 2, 263, 224, 0, 3);
        send_lines(0, 262);
        expect_frame(8, 3, 2, 263, 224, 1, 3);
        send_lines(0, 262);

        // Line length shrinks by one pixel: lock drops, then returns after two matching frames
        ce_div = 1;
        htot   = 7;
        expect_frame(7, 3, 2, 263, 224, 0, 2);
        send_lines(0, 262);
        expect_frame(7, 3, 2, 263, 224, 0, 2);
        send_lines(0, 262);
        expect_frame(7, 3, 2, 263, 224, 1, 2);
        send_lines(0, 262);

        // Loss of sync
        repeat (600) pix(1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        chk("los_hpos_saturated", int'(hpos), 511);
        chk("los_locked", int'(locked), 0);
        expect_frame(7, 3, 2, 263, 224, 0, 2);
        send_lines(0, 262);
        expect_frame(7, 3, 2, 263, 224, 0, 2);
        send_lines(0, 262);
        expect_frame(7, 3, 2, 263, 224, 1, 2);
        send_lines(0, 262);

        // vs leading edge on the same sample as an hs leading edge
        vs_px = 5;
        expect_frame(7, 3, 2, 263, 224, 1, 0);
        send_lines(0, 262);
        expect_frame(7, 3, 2, 263, 224, 1, 0);
        send_lines(0, 262);

        // Reset mid-frame while locked
        send_lines(0, 99);
        settle();
        chk("mid_vpos", int'(vpos), 128);
        chk("mid_hpos", int'(hpos), 1);
        chk("mid_locked", int'(locked), 1);
        @(negedge clk_sys);
        reset = 1'b1;
        #1;
        check_zero("midreset");
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        expect_frame(7, 3, 2, 0, 0, 0, 0);
        send_lines(100, 262);
        expect_frame(7, 3, 2, 263, 224, 0, 0);
        send_lines(0, 262);

        settle();
        repeat (5) @(negedge clk_sys);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("frames_seen", n_pop, n_push);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
